instr_fetch: RTL and testbench

Fetch stage between the program counter and the decode/execute stage. Each cycle of its state machine it presents the current PC to the synchronous instruction ROM and captures the returned word. Jumps are resolved locally by driving the counter's load controls; every other instruction goes downstream through a valid/ready handshake. A HALT opcode stops all fetching until reset.

---
 rtl/instr_fetch.sv | 149 ++++++++++++++
 tb/tb_instr_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage between the program counter and decode/execute. It walks a
// small state machine (IDLE -> FETCH -> CAPTURE -> HOLD) that presents the
// current PC to a synchronous ROM, captures the returned word one cycle later,
// resolves unconditional jumps locally by loading the counter, and hands all
// other instructions downstream through a valid/ready handshake. A HALT
// opcode is forwarded once and then parks the block in HALTED until reset.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   pc           current program counter value
//   rom_en       ROM read strobe (FETCH only)
//   rom_addr     ROM read address (= pc during FETCH, else 0)
//   rom_rdata    ROM word, valid the cycle after rom_en
//   pc_ce        counter enable (pulsed in CAPTURE for non-HALT words)
//   pc_jmp       counter load select (CAPTURE of a jump only)
//   pc_target    counter load value (jump operand, else 0)
//   instr        captured instruction word
//   instr_pc     address instr was fetched from
//   instr_valid  instr/instr_pc valid (HOLD)
//   instr_ready  downstream accepts (only looked at in HOLD)
//   halted       high in HALTED
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int                      CNTR_WIDTH   = 8,
  parameter int                      OPCODE_WIDTH = 4,
  parameter int                      INSTR_WIDTH  = OPCODE_WIDTH + CNTR_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] JMP_OPCODE   = 4'hE,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNTR_WIDTH-1:0]  pc,
  output logic                   rom_en,
  output logic [CNTR_WIDTH-1:0]  rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_rdata,
  output logic                   pc_ce,
  output logic                   pc_jmp,
  output logic [CNTR_WIDTH-1:0]  pc_target,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [CNTR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;

  logic [2:0]             state_q,    state_d;
  logic [INSTR_WIDTH-1:0] instr_q,    instr_d;
  logic [CNTR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
  logic                   halt_q,     halt_d;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [CNTR_WIDTH-1:0]   operand;

  assign opcode  = rom_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign operand = rom_rdata[CNTR_WIDTH-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    halt_d      = halt_q;
    rom_en      = 1'b0;
    rom_addr    = '0;
    pc_ce       = 1'b0;
    pc_jmp      = 1'b0;
    pc_target   = '0;
    instr_valid = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        rom_en     = 1'b1;
        rom_addr   = pc;
        instr_pc_d = pc;
        state_d    = ST_CAPTURE;
      end

      // rom_rdata is only meaningful here: it is the word requested in FETCH.
      ST_CAPTURE: begin
        if (opcode == JMP_OPCODE) begin
          // Jumps are consumed locally and never reach downstream.
          pc_ce     = 1'b1;
          pc_jmp    = 1'b1;
          pc_target = operand;
          state_d   = ST_FETCH;
        end else if (opcode == HALT_OPCODE) begin
          // PC is left on the halt address.
          instr_d = rom_rdata;
          halt_d  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          pc_ce   = 1'b1;
          instr_d = rom_rdata;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_d = halt_q ? ST_HALTED : ST_FETCH;
        end
      end

      ST_HALTED: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      halt_q     <= halt_d;
    end
  end

  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. Surrounds the DUT with a synchronous ROM and
// a loadable program counter (the counter has its own reset so the DUT can be
// reset alone), then walks sequential fetch, backpressure, halt, jump,
// reset-in-HOLD and self-jump scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_rst;
  logic [7:0]  pc;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [11:0] rom_rdata;
  logic        pc_ce;
  logic        pc_jmp;
  logic [7:0]  pc_target;
  logic [11:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  logic [11:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .pc_ce       (pc_ce),
    .pc_jmp      (pc_jmp),
    .pc_target   (pc_target),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  // Synchronous ROM: word appears the cycle after rom_en.
  always_ff @(posedge clk) begin
    if (rom_en) rom_rdata <= mem[rom_addr];
  end

  // Program counter: load on pc_ce & pc_jmp, increment on pc_ce alone.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst)      pc <= 8'h00;
    else if (pc_ce)  pc <= pc_jmp ? pc_target : pc + 8'h01;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at the FETCH sample point, leaves at the first HOLD sample point.
  task automatic fetch_seq(input logic [7:0] addr, input logic [11:0] word, input bit is_halt);
    chk("fetch_rom_en",   32'(rom_en), 1);
    chk("fetch_rom_addr", 32'(rom_addr), 32'(addr));
    chk("fetch_pc_ce",    32'(pc_ce), 0);
    step();
    chk("cap_pc_ce",      32'(pc_ce), is_halt ? 0 : 1);
    chk("cap_pc_jmp",     32'(pc_jmp), 0);
    chk("cap_pc_target",  32'(pc_target), 0);
    chk("cap_valid",      32'(instr_valid), 0);
    chk("cap_rom_en",     32'(rom_en), 0);
    step();
    chk("hold_valid",     32'(instr_valid), 1);
    chk("hold_instr",     32'(instr), 32'(word));
    chk("hold_instr_pc",  32'(instr_pc), 32'(addr));
    chk("hold_pc_ce",     32'(pc_ce), 0);
    chk("hold_rom_en",    32'(rom_en), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_en"},    32'(rom_en), 0);
    chk({tag, "_rom_addr"},  32'(rom_addr), 0);
    chk({tag, "_pc_ce"},     32'(pc_ce), 0);
    chk({tag, "_pc_jmp"},    32'(pc_jmp), 0);
    chk({tag, "_pc_target"}, 32'(pc_target), 0);
    chk({tag, "_instr"},     32'(instr), 0);
    chk({tag, "_instr_pc"},  32'(instr_pc), 0);
    chk({tag, "_valid"},     32'(instr_valid), 0);
    chk({tag, "_halted"},    32'(halted), 0);
  endtask

  initial begin
    rst         = 1'b1;
    pc_rst      = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    mem[0] = 12'h105;
    mem[1] = 12'h207;
    mem[2] = 12'h3AA;
    mem[3] = 12'hF00;

    // ---------------- reset state ----------------
    step();
    chk_all_zero("rst");
    rst    = 1'b0;
    pc_rst = 1'b0;
    chk("idle_rom_en", 32'(rom_en), 0);
    step();

    // ---------------- sequential fetch ----------------
    fetch_seq(8'h00, 12'h105, 1'b0);
    step();
    fetch_seq(8'h01, 12'h207, 1'b0);
    step();

    // ---------------- backpressure on the third word ----------------
    instr_ready = 1'b0;
    fetch_seq(8'h02, 12'h3AA, 1'b0);
    chk("bp_pc", 32'(pc), 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid",    32'(instr_valid), 1);
      chk("bp_instr",    32'(instr), 'h3AA);
      chk("bp_instr_pc", 32'(instr_pc), 2);
      chk("bp_rom_en",   32'(rom_en), 0);
      chk("bp_pc_ce",    32'(pc_ce), 0);
      chk("bp_pc",       32'(pc), 3);
    end
    instr_ready = 1'b1;
    chk("bp_release_valid", 32'(instr_valid), 1);
    step();

    // ---------------- halt ----------------
    fetch_seq(8'h03, 12'hF00, 1'b1);
    chk("halt_hold_halted", 32'(halted), 0);
    step();
    chk("halted",         32'(halted), 1);
    chk("halted_valid",   32'(instr_valid), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halted_rom_en", 32'(rom_en), 0);
      chk("halted_pc_ce",  32'(pc_ce), 0);
      chk("halted_pc",     32'(pc), 3);
      chk("halted_flag",   32'(halted), 1);
    end

    // ---------------- jump ----------------
    rst    = 1'b1;
    pc_rst = 1'b1;
    #1;
    chk_all_zero("rst2");
    mem[1]    = 12'hE10;
    mem[8'h10] = 12'h455;
    mem[8'h11] = 12'hE05;
    mem[5]    = 12'hE05;
    step();
    rst    = 1'b0;
    pc_rst = 1'b0;
    step();
    fetch_seq(8'h00, 12'h105, 1'b0);
    step();
    chk("jf_rom_en",   32'(rom_en), 1);
    chk("jf_rom_addr", 32'(rom_addr), 1);
    step();
    chk("jc_pc_ce",     32'(pc_ce), 1);
    chk("jc_pc_jmp",    32'(pc_jmp), 1);
    chk("jc_pc_target", 32'(pc_target), 'h10);
    chk("jc_valid",     32'(instr_valid), 0);
    instr_ready = 1'b0;
    step();
    chk("jt_rom_en",    32'(rom_en), 1);
    chk("jt_rom_addr",  32'(rom_addr), 'h10);
    chk("jt_pc_jmp",    32'(pc_jmp), 0);
    chk("jt_pc_target", 32'(pc_target), 0);
    step();
    chk("jt_cap_pc_ce",  32'(pc_ce), 1);
    chk("jt_cap_pc_jmp", 32'(pc_jmp), 0);
    step();
    chk("jt_valid",    32'(instr_valid), 1);
    chk("jt_instr",    32'(instr), 'h455);
    chk("jt_instr_pc", 32'(instr_pc), 'h10);
    step();
    chk("jt_hold2_valid", 32'(instr_valid), 1);

    // ---------------- reset mid-HOLD (DUT only, counter keeps 0x11) -------
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    step();
    rst         = 1'b0;
    instr_ready = 1'b1;
    chk("mid_rst_pc", 32'(pc), 'h11);
    step();
    chk("restart_rom_en",   32'(rom_en), 1);
    chk("restart_rom_addr", 32'(rom_addr), 'h11);
    step();
    chk("restart_pc_jmp",    32'(pc_jmp), 1);
    chk("restart_pc_target", 32'(pc_target), 5);

    // ---------------- self-jump at 5 ----------------
    for (int i = 0; i < 4; i++) begin
      step();
      chk("self_f_rom_en",   32'(rom_en), 1);
      chk("self_f_rom_addr", 32'(rom_addr), 5);
      chk("self_f_valid",    32'(instr_valid), 0);
      step();
      chk("self_c_rom_en",    32'(rom_en), 0);
      chk("self_c_pc_jmp",    32'(pc_jmp), 1);
      chk("self_c_pc_target", 32'(pc_target), 5);
      chk("self_c_valid",     32'(instr_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
